nibble_dp_scheduler: RTL and testbench
======================================

Name: nibble_dp_scheduler

Overview:
- Schedules a single shared 4-bit processing datapath (handshake `in` / `out_valid` / `out`) between two requesters, A and B.
- Arbitrates between the requesters round-robin, issues one nibble per transaction to the datapath and waits for its result, with a timeout.
- Returns the result, or an error, to the requester that was granted, tagged with its id.
- Sits between the requester logic and the datapath instance; the datapath itself is unchanged.

Parameters:
DW, 4, data width of the requester payloads and of the datapath in/out.
TIMEOUT, 15, maximum number of WAIT cycles allowed for dp_out_valid; legal range 1..2**CW-1.
CW, 4, width of the timeout counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
req_a  input  1  requester A request; held high until gnt_a is seen.
data_a  input  DW  requester A payload; stable while req_a is high.
gnt_a  output  1  one-cycle grant to A.
req_b  input  1  requester B request.
data_b  input  DW  requester B payload.
gnt_b  output  1  one-cycle grant to B.
dp_in_valid  output  1  one-cycle issue strobe to the datapath.
dp_in  output  DW  payload to the datapath; 0 when dp_in_valid is low.
dp_out_valid  input  1  datapath result strobe.
dp_out  input  DW  datapath result.
resp_valid  output  1  one-cycle response strobe.
resp_id  output  1  0 = A, 1 = B; valid with resp_valid.
resp_data  output  DW  captured result; 0 on error.
resp_err  output  1  1 = timeout occurred.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: asynchronous, takes effect immediately.
  - All outputs return to 0; state goes to IDLE; timeout counter to 0.
  - Round-robin pointer last_id is set to 1, so A wins the first tie.
  - An in-flight transaction is dropped and produces no response.
- All outputs are registered.
- FSM IDLE: at the clock edge, if req_a or req_b is high:
  - Choose the winner. With one requester, it wins. With both, the winner is !last_id.
  - Latch the winner's data and id; set last_id to the winner; go to ISSUE.
  - With no request, stay in IDLE.
- FSM ISSUE (exactly one cycle):
  - gnt_<winner> = 1, dp_in_valid = 1, dp_in = latched data.
  - Clear the counter; go to WAIT.
  - dp_out_valid is ignored in this cycle.
- FSM WAIT:
  - If dp_out_valid = 1: capture dp_out, set err = 0, go to RESP.
  - Else, if counter == TIMEOUT-1: set data = 0, err = 1, go to RESP.
  - Otherwise increment the counter and stay.
  - WAIT therefore lasts at most TIMEOUT cycles. dp_out_valid arriving in the final WAIT cycle counts as success (success has priority over timeout).
- FSM RESP (one cycle): resp_valid = 1 with resp_id, resp_data and resp_err; then go to IDLE.
- Ignored inputs: dp_out_valid outside WAIT is ignored, including late results after a timeout. No response or state change results.
- Requester rule: the requester drops req in the cycle after its gnt.
  - A req still high when the FSM is back in IDLE is treated as a new request.
  - Requests arriving while busy = 1 wait; they are not lost, because the requester holds req.
- Minimum turnaround:
  - req high sampled at edge 0.
  - gnt and dp_in_valid in cycle 1.
  - dp_out_valid in cycle 2.
  - resp_valid in cycle 3.
  - IDLE in cycle 4.
  - The earliest next gnt is in cycle 5.
- gnt_a and gnt_b are never high together. resp_valid never coincides with dp_in_valid.

Test Plan:
1. Reset with both req_a/req_b high and data_a = 4'h3, data_b = 4'h9 -> gnt_a first, dp_in = 3. Datapath returns 4'h7 one cycle later -> resp_valid, resp_id = 0, resp_data = 7, resp_err = 0, exactly 3 cycles after the first sampled req. Next grant goes to B with dp_in = 9.
2. Only req_b active, three back-to-back transactions -> B is granted each time; no gnt_a; each transaction takes 4 cycles minimum.
3. Datapath never answers -> after exactly 15 WAIT cycles, resp_valid with resp_err = 1 and resp_data = 0. A dp_out_valid one cycle later is ignored.
4. dp_out_valid = 1 with dp_out = 4'hE on the 15th WAIT cycle -> resp_err = 0, resp_data = E.
5. Assert rst asynchronously mid-WAIT -> all outputs 0 immediately, no resp_valid. After release with both requesters active, A is granted first.
6. Both requesters held high continuously for 8 transactions -> grants alternate A,B,A,B...; resp_id matches each grant.

Source files
------------

// File: rtl/nibble_dp_scheduler.sv
// Round-robin scheduler that shares one 4-bit datapath between requesters A and B,
// issuing one nibble per transaction and returning the result (or a timeout error).
module nibble_dp_scheduler #(
  parameter int unsigned DW      = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_b,
  output logic          dp_in_valid,
  output logic [DW-1:0] dp_in,
  input  logic          dp_out_valid,
  input  logic [DW-1:0] dp_out,
  output logic          resp_valid,
  output logic          resp_id,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_id_q, last_id_d;
  logic          id_q, id_d;

  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          dp_in_valid_q, dp_in_valid_d;
  logic [DW-1:0] dp_in_q, dp_in_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_id_q, resp_id_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic          busy_q, busy_d;

  logic          win_b;

  // B wins when it is alone, or when both request and A was served last.
  assign win_b = req_b && (!req_a || !last_id_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_id_d     = last_id_q;
    id_d          = id_q;
    gnt_a_d       = 1'b0;
    gnt_b_d       = 1'b0;
    dp_in_valid_d = 1'b0;
    dp_in_d       = '0;
    resp_valid_d  = 1'b0;
    resp_id_d     = 1'b0;
    resp_data_d   = '0;
    resp_err_d    = 1'b0;

    // Outputs are registered, so each one is decoded from the state being entered.
    unique case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_d       = S_ISSUE;
          id_d          = win_b;
          last_id_d     = win_b;
          gnt_a_d       = !win_b;
          gnt_b_d       = win_b;
          dp_in_valid_d = 1'b1;
          dp_in_d       = win_b ? data_b : data_a;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dp_out_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_data_d  = dp_out;
          resp_err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_id_q     <= 1'b1;
      id_q          <= 1'b0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      dp_in_valid_q <= 1'b0;
      dp_in_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_id_q     <= last_id_d;
      id_q          <= id_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      dp_in_valid_q <= dp_in_valid_d;
      dp_in_q       <= dp_in_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign dp_in_valid = dp_in_valid_q;
  assign dp_in       = dp_in_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nibble_dp_scheduler.sv
// Directed bench for nibble_dp_scheduler: arbitration order, turnaround, timeout
// boundary, ignored late results and asynchronous reset.
module tb_nibble_dp_scheduler;

  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic [3:0] data_a, data_b;
  logic       gnt_a, gnt_b;
  logic       dp_in_valid;
  logic [3:0] dp_in;
  logic       dp_out_valid;
  logic [3:0] dp_out;
  logic       resp_valid, resp_id, resp_err, busy;
  logic [3:0] resp_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  nibble_dp_scheduler #(.DW(4), .TIMEOUT(15), .CW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_a        (req_a),
    .data_a       (data_a),
    .gnt_a        (gnt_a),
    .req_b        (req_b),
    .data_b       (data_b),
    .gnt_b        (gnt_b),
    .dp_in_valid  (dp_in_valid),
    .dp_in        (dp_in),
    .dp_out_valid (dp_out_valid),
    .dp_out       (dp_out),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {gnt_a,gnt_b,dp_in_valid,dp_in,resp_valid,resp_id,resp_data,resp_err,busy} packed.
  function automatic logic [31:0] outs();
    return {17'd0, gnt_a, gnt_b, dp_in_valid, dp_in, resp_valid, resp_id, resp_data, resp_err, busy};
  endfunction

  initial begin
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    dp_out_valid = 1'b0; dp_out = '0;

    // 1: reset with both requesting, A wins, 3-cycle latency, then B
    #1 rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'h9;
    #1 chk("reset_outs", outs(), 32'd0);
    tick;
    chk("reset_held_outs", outs(), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick;
    chk("t1_gnt_a", gnt_a, 1'b1);
    chk("t1_gnt_b", gnt_b, 1'b0);
    chk("t1_dp_in_valid", dp_in_valid, 1'b1);
    chk("t1_dp_in", dp_in, 4'h3);
    chk("t1_busy", busy, 1'b1);
    req_a = 1'b0;
    tick;
    chk("t1_wait_quiet", {gnt_a, gnt_b, dp_in_valid, dp_in, resp_valid}, 8'h00);
    dp_out_valid = 1'b1; dp_out = 4'h7;
    tick;
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp", {resp_id, resp_data, resp_err}, {1'b0, 4'h7, 1'b0});
    chk("t1_resp_no_issue", dp_in_valid, 1'b0);
    dp_out_valid = 1'b0; dp_out = '0;
    tick;
    chk("t1_idle", {resp_valid, busy, gnt_b}, 3'b000);
    tick;
    chk("t1_next_gnt_b", {gnt_a, gnt_b, dp_in}, {1'b0, 1'b1, 4'h9});
    req_b = 1'b0;
    tick;
    dp_out_valid = 1'b1; dp_out = 4'h5;
    tick;
    chk("t1_b_resp", {resp_valid, resp_id, resp_data, resp_err}, {1'b1, 1'b1, 4'h5, 1'b0});
    dp_out_valid = 1'b0;
    tick;
    chk("t1_b_idle", busy, 1'b0);

    // 2: B alone, three back-to-back transactions, 4 cycles each
    req_b = 1'b1; data_b = 4'h1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t2_gnt", {gnt_a, gnt_b, dp_in_valid, dp_in}, {3'b011, 4'(i + 1)});
      req_b = 1'b0;
      tick;
      chk("t2_wait_no_gnt", {gnt_a, gnt_b}, 2'b00);
      dp_out_valid = 1'b1; dp_out = 4'(i + 8);
      tick;
      chk("t2_resp", {resp_valid, resp_id, resp_data, resp_err, gnt_a}, {2'b11, 4'(i + 8), 2'b00});
      dp_out_valid = 1'b0;
      if (i < 2) begin
        req_b = 1'b1; data_b = 4'(i + 2);
      end
      tick;
      chk("t2_idle", {busy, gnt_a, gnt_b, resp_valid}, 4'b0000);
    end

    // 3: timeout after exactly 15 WAIT cycles; result during ISSUE and late result ignored
    req_a = 1'b1; data_a = 4'h4;
    tick;
    chk("t3_gnt_a", {gnt_a, dp_in}, {1'b1, 4'h4});
    req_a = 1'b0;
    dp_out_valid = 1'b1; dp_out = 4'hF;
    tick;
    dp_out_valid = 1'b0; dp_out = '0;
    chk("t3_in_wait", {busy, resp_valid}, 2'b10);
    for (int k = 0; k < 14; k++) begin
      tick;
      chk("t3_no_resp_yet", {busy, resp_valid}, 2'b10);
    end
    tick;
    chk("t3_timeout_resp", {resp_valid, resp_id, resp_data, resp_err}, {2'b10, 4'h0, 1'b1});
    dp_out_valid = 1'b1; dp_out = 4'hA;
    tick;
    chk("t3_late_ignored", {resp_valid, busy}, 2'b00);
    tick;
    chk("t3_still_idle", outs(), 32'd0);
    dp_out_valid = 1'b0; dp_out = '0;

    // 4: result in the 15th WAIT cycle wins over timeout
    req_b = 1'b1; data_b = 4'h2;
    tick;
    chk("t4_gnt_b", {gnt_b, dp_in}, {1'b1, 4'h2});
    req_b = 1'b0;
    tick;
    for (int k = 0; k < 14; k++) tick;
    chk("t4_no_resp_yet", resp_valid, 1'b0);
    dp_out_valid = 1'b1; dp_out = 4'hE;
    tick;
    chk("t4_last_cycle_ok", {resp_valid, resp_id, resp_data, resp_err}, {2'b11, 4'hE, 1'b0});
    dp_out_valid = 1'b0; dp_out = '0;
    tick;

    // 5: asynchronous reset in WAIT drops the transaction; A wins the next tie
    req_a = 1'b1; data_a = 4'h6;
    tick;
    chk("t5_gnt_a", gnt_a, 1'b1);
    req_a = 1'b0;
    tick;
    tick;
    chk("t5_busy_mid_wait", busy, 1'b1);
    rst = 1'b1;
    #1 chk("t5_async_reset_outs", outs(), 32'd0);
    req_a = 1'b1; req_b = 1'b1; data_a = 4'hC; data_b = 4'hD;
    dp_out_valid = 1'b1; dp_out = 4'h3;
    tick;
    chk("t5_reset_no_resp", outs(), 32'd0);
    dp_out_valid = 1'b0; dp_out = '0;
    @(negedge clk) rst = 1'b0;
    tick;

    // 6: both held high for 8 transactions, strict alternation starting with A
    for (int t = 0; t < 8; t++) begin
      if (t > 0) tick;
      chk("t6_gnt", {gnt_a, gnt_b, dp_in}, (t % 2 == 0) ? {2'b10, 4'hC} : {2'b01, 4'hD});
      tick;
      dp_out_valid = 1'b1; dp_out = 4'(t) ^ 4'h5;
      tick;
      chk("t6_resp", {resp_valid, resp_id, resp_data, resp_err},
          {1'b1, 1'(t % 2), 4'(t) ^ 4'h5, 1'b0});
      dp_out_valid = 1'b0;
      tick;
      chk("t6_idle", busy, 1'b0);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick;
    tick;
    chk("final_idle", outs(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
